// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: loader state encoding, descriptor
// field positions and memory geometry.
package operand_loader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int MNT_W  = 12;

  localparam int M_HI = 11;
  localparam int M_LO = 8;
  localparam int N_HI = 7;
  localparam int N_LO = 4;
  localparam int T_HI = 3;
  localparam int T_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_W,
    FLUSH,
    KICK
  } state_e;

endpackage

// File: rtl/operand_loader_if.sv
// Host stream, descriptor and IMEM/WMEM write-port bundle for the loader.
// The host/bench drives through master; the loader uses slave.
interface operand_loader_if;

  logic                                LOAD_REQ;
  logic [operand_loader_pkg::MNT_W-1:0]  MNT;
  logic                                S_VALID;
  logic [operand_loader_pkg::DATA_W-1:0] S_DATA;
  logic                                S_READY;

  logic                                EN_I;
  logic                                RW_I;
  logic [operand_loader_pkg::ADDR_W-1:0] ADDR_I;
  logic [operand_loader_pkg::DATA_W-1:0] WDATA_I;

  logic                                EN_W;
  logic                                RW_W;
  logic [operand_loader_pkg::ADDR_W-1:0] ADDR_W;
  logic [operand_loader_pkg::DATA_W-1:0] WDATA_W;

  logic [operand_loader_pkg::MNT_W-1:0]  MNT_O;
  logic                                START;
  logic                                BUSY;
  logic                                ERR;

  modport master (
    output LOAD_REQ, MNT, S_VALID, S_DATA,
    input  S_READY,
    input  EN_I, RW_I, ADDR_I, WDATA_I,
    input  EN_W, RW_W, ADDR_W, WDATA_W,
    input  MNT_O, START, BUSY, ERR
  );

  modport slave (
    input  LOAD_REQ, MNT, S_VALID, S_DATA,
    output S_READY,
    output EN_I, RW_I, ADDR_I, WDATA_I,
    output EN_W, RW_W, ADDR_W, WDATA_W,
    output MNT_O, START, BUSY, ERR
  );

endinterface

// File: rtl/operand_loader.sv
// Streams M host words into IMEM, then N words into WMEM, and kicks the MAC
// array once the final weight write has been presented.
module operand_loader
  import operand_loader_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  operand_loader_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [MNT_W-1:0]    mnt_q, mnt_d;
  logic                err_q, err_d;

  logic                en_i_q, en_i_d, rw_i_q, rw_i_d;
  logic [ADDR_W-1:0]   addr_i_q, addr_i_d;
  logic [DATA_W-1:0]   wdata_i_q, wdata_i_d;
  logic                en_w_q, en_w_d, rw_w_q, rw_w_d;
  logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
  logic [DATA_W-1:0]   wdata_w_q, wdata_w_d;

  logic [ADDR_W-1:0]   m_cnt, n_cnt, req_m, req_n;
  logic                s_ready, beat;

  assign m_cnt   = mnt_q[M_HI:M_LO];
  assign n_cnt   = mnt_q[N_HI:N_LO];
  assign req_m   = bus.MNT[M_HI:M_LO];
  assign req_n   = bus.MNT[N_HI:N_LO];
  assign s_ready = (state_q == LOAD_I) || (state_q == LOAD_W);
  assign beat    = s_ready && bus.S_VALID;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mnt_d     = mnt_q;
    err_d     = err_q;
    en_i_d    = 1'b0;
    rw_i_d    = 1'b0;
    addr_i_d  = addr_i_q;
    wdata_i_d = wdata_i_q;
    en_w_d    = 1'b0;
    rw_w_d    = 1'b0;
    addr_w_d  = addr_w_q;
    wdata_w_d = wdata_w_q;

    case (state_q)
      IDLE: begin
        if (bus.LOAD_REQ) begin
          // Descriptor is latched even when rejected so the host can see what failed.
          mnt_d = {req_m, req_n, bus.MNT[T_HI:T_LO]};
          cnt_d = '0;
          if ((req_m == '0) || (req_n == '0)) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD_I;
          end
        end
      end
      LOAD_I: begin
        if (beat) begin
          en_i_d    = 1'b1;
          rw_i_d    = 1'b1;
          addr_i_d  = cnt_q;
          wdata_i_d = bus.S_DATA;
          if (cnt_q == m_cnt - 4'd1) begin
            cnt_d   = '0;
            state_d = LOAD_W;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      LOAD_W: begin
        if (beat) begin
          en_w_d    = 1'b1;
          rw_w_d    = 1'b1;
          addr_w_d  = cnt_q;
          wdata_w_d = bus.S_DATA;
          if (cnt_q == n_cnt - 4'd1) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      // The last weight write sits on the WMEM port during FLUSH.
      FLUSH:   state_d = KICK;
      KICK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mnt_q     <= '0;
      err_q     <= 1'b0;
      en_i_q    <= 1'b0;
      rw_i_q    <= 1'b0;
      addr_i_q  <= '0;
      wdata_i_q <= '0;
      en_w_q    <= 1'b0;
      rw_w_q    <= 1'b0;
      addr_w_q  <= '0;
      wdata_w_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mnt_q     <= mnt_d;
      err_q     <= err_d;
      en_i_q    <= en_i_d;
      rw_i_q    <= rw_i_d;
      addr_i_q  <= addr_i_d;
      wdata_i_q <= wdata_i_d;
      en_w_q    <= en_w_d;
      rw_w_q    <= rw_w_d;
      addr_w_q  <= addr_w_d;
      wdata_w_q <= wdata_w_d;
    end
  end

  assign bus.S_READY = s_ready;
  assign bus.EN_I    = en_i_q;
  assign bus.RW_I    = rw_i_q;
  assign bus.ADDR_I  = addr_i_q;
  assign bus.WDATA_I = wdata_i_q;
  assign bus.EN_W    = en_w_q;
  assign bus.RW_W    = rw_w_q;
  assign bus.ADDR_W  = addr_w_q;
  assign bus.WDATA_W = wdata_w_q;
  assign bus.MNT_O   = mnt_q;
  assign bus.START   = (state_q == KICK);
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.ERR     = err_q;

endmodule
